// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin arbiter sharing one req/gnt/rvalid device port
// One transaction outstanding at the device, with a watchdog that retires hung transactions.

module bus_rr_arbiter #(
    parameter int NrHosts       = 2,
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NrHosts-1:0]     host_req_i,
    output logic [NrHosts-1:0]     host_gnt_o,
    input  logic [AddrWidth-1:0]   host_addr_i  [NrHosts],
    input  logic [NrHosts-1:0]     host_we_i,
    input  logic [DataWidth/8-1:0] host_be_i    [NrHosts],
    input  logic [DataWidth-1:0]   host_wdata_i [NrHosts],
    output logic [NrHosts-1:0]     host_rvalid_o,
    output logic [DataWidth-1:0]   host_rdata_o [NrHosts],
    output logic [NrHosts-1:0]     host_err_o,
    output logic                   dev_req_o,
    input  logic                   dev_gnt_i,
    output logic [AddrWidth-1:0]   dev_addr_o,
    output logic                   dev_we_o,
    output logic [DataWidth/8-1:0] dev_be_o,
    output logic [DataWidth-1:0]   dev_wdata_o,
    input  logic                   dev_rvalid_i,
    input  logic [DataWidth-1:0]   dev_rdata_i,
    input  logic                   dev_err_i
);

    localparam int IdxW = $clog2(NrHosts);
    localparam int CntW = $clog2(TimeoutCycles);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   prio_q, prio_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              any_req;
    logic [IdxW-1:0]   winner;
    logic              arb_en;
    int                idx;

    // Scan hosts starting at the priority pointer, wrapping at NrHosts.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = 0;
        for (int i = 0; i < NrHosts; i++) begin
            idx = int'(prio_q) + i;
            if (idx >= NrHosts) begin
                idx = idx - NrHosts;
            end
            if (!any_req && host_req_i[idx]) begin
                any_req = 1'b1;
                winner  = IdxW'(idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        prio_d        = prio_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        arb_en        = 1'b0;
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        for (int i = 0; i < NrHosts; i++) begin
            host_rdata_o[i] = '0;
        end
        dev_req_o     = 1'b0;
        dev_addr_o    = '0;
        dev_we_o      = 1'b0;
        dev_be_o      = '0;
        dev_wdata_o   = '0;

        case (state_q)
            S_IDLE: begin
                arb_en = 1'b1;
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (dev_rvalid_i) begin
                    host_rvalid_o[owner_q] = 1'b1;
                    host_rdata_o[owner_q]  = dev_rdata_i;
                    host_err_o[owner_q]    = dev_err_i;
                    arb_en                 = 1'b1;
                    state_d                = S_IDLE;
                end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    // Watchdog: retire the hung transaction as an error, no issue this cycle.
                    host_rvalid_o[owner_q] = 1'b1;
                    host_err_o[owner_q]    = 1'b1;
                    state_d                = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (arb_en && any_req) begin
            dev_req_o   = 1'b1;
            dev_addr_o  = host_addr_i[winner];
            dev_we_o    = host_we_i[winner];
            dev_be_o    = host_be_i[winner];
            dev_wdata_o = host_wdata_i[winner];
            if (dev_gnt_i) begin
                host_gnt_o[winner] = 1'b1;
                owner_d            = winner;
                prio_d             = (winner == IdxW'(NrHosts - 1)) ? '0 : winner + 1'b1;
                cnt_d              = '0;
                state_d            = S_BUSY;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            prio_q  <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - directed self-checking bench for bus_rr_arbiter
// Inputs change on the falling edge; outputs are sampled 1ns later.

module tb_bus_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  host_req, host_gnt, host_we, host_rvalid, host_err;
    logic [31:0] host_addr  [2];
    logic [3:0]  host_be    [2];
    logic [31:0] host_wdata [2];
    logic [31:0] host_rdata [2];
    logic        dev_req, dev_gnt, dev_we, dev_rvalid, dev_err;
    logic [31:0] dev_addr, dev_wdata, dev_rdata;
    logic [3:0]  dev_be;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_rr_arbiter #(
        .NrHosts(2), .AddrWidth(32), .DataWidth(32), .TimeoutCycles(64)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
        .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
        .dev_req_o(dev_req), .dev_gnt_i(dev_gnt), .dev_addr_o(dev_addr), .dev_we_o(dev_we),
        .dev_be_o(dev_be), .dev_wdata_o(dev_wdata), .dev_rvalid_i(dev_rvalid),
        .dev_rdata_i(dev_rdata), .dev_err_i(dev_err)
    );

    task automatic idle_inputs();
        host_req   = '0;
        host_we    = '0;
        host_addr[0] = 32'h0000_0100;
        host_addr[1] = 32'h0000_0200;
        host_be[0] = 4'hF;
        host_be[1] = 4'hF;
        host_wdata[0] = '0;
        host_wdata[1] = '0;
        dev_gnt    = 1'b0;
        dev_rvalid = 1'b0;
        dev_rdata  = '0;
        dev_err    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (dev_req !== 1'b0) begin errors++; $display("FAIL rst_dev_req got=%b exp=0", dev_req); end
        checks++; if (host_gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt got=%b exp=00", host_gnt); end
        checks++; if (host_rvalid !== 2'b00 || host_err !== 2'b00) begin errors++; $display("FAIL rst_rvalid_err got=%b/%b exp=00/00", host_rvalid, host_err); end
        checks++; if (dev_addr !== 32'h0 || dev_be !== 4'h0) begin errors++; $display("FAIL rst_dev_fields got=%h/%h exp=0/0", dev_addr, dev_be); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk);
        host_req = 2'b01; dev_gnt = 1'b1;
        #1;
        checks++; if (host_gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got=%b exp=01", host_gnt); end
        checks++; if (dev_req !== 1'b1 || dev_addr !== 32'h100 || dev_we !== 1'b0) begin errors++; $display("FAIL single_dev got=%b/%h/%b exp=1/00000100/0", dev_req, dev_addr, dev_we); end
        @(negedge clk);
        host_req = 2'b00; dev_gnt = 1'b0; dev_rvalid = 1'b1; dev_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (host_rvalid !== 2'b01) begin errors++; $display("FAIL single_rvalid got=%b exp=01", host_rvalid); end
        checks++; if (host_rdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata0 got=%h exp=deadbeef", host_rdata[0]); end
        checks++; if (host_rdata[1] !== 32'h0 || host_err !== 2'b00 || host_gnt !== 2'b00) begin errors++; $display("FAIL single_host1_quiet got=%h/%b/%b exp=0/00/00", host_rdata[1], host_err, host_gnt); end
        @(negedge clk);
        dev_rvalid = 1'b0; dev_rdata = '0;
        #1;
        checks++; if (dev_req !== 1'b0 || host_rvalid !== 2'b00) begin errors++; $display("FAIL single_idle_after got=%b/%b exp=0/00", dev_req, host_rvalid); end
    endtask

    task automatic test_alternate();
        logic [1:0] exp_gnt, exp_rv;
        logic [31:0] rd;
        int owner;
        do_reset();
        @(negedge clk);
        host_req = 2'b11; dev_gnt = 1'b1;
        #1;
        checks++; if (host_gnt !== 2'b01) begin errors++; $display("FAIL alt_first_gnt got=%b exp=01", host_gnt); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            rd = 32'hA000_0000 + k;
            dev_rvalid = 1'b1; dev_rdata = rd;
            #1;
            owner   = (k % 2 == 1) ? 0 : 1;
            exp_rv  = (owner == 0) ? 2'b01 : 2'b10;
            exp_gnt = (owner == 0) ? 2'b10 : 2'b01;
            checks++; if (host_rvalid !== exp_rv || host_rdata[owner] !== rd) begin errors++; $display("FAIL alt_resp k=%0d got=%b/%h exp=%b/%h", k, host_rvalid, host_rdata[owner], exp_rv, rd); end
            checks++; if (host_gnt !== exp_gnt) begin errors++; $display("FAIL alt_gnt k=%0d got=%b exp=%b", k, host_gnt, exp_gnt); end
        end
        @(negedge clk);
        host_req = 2'b00; dev_gnt = 1'b0; dev_rdata = 32'hA000_0005;
        #1;
        checks++; if (host_rvalid !== 2'b01 || host_gnt !== 2'b00 || host_rdata[0] !== 32'hA000_0005) begin errors++; $display("FAIL alt_last got=%b/%b/%h exp=01/00/a0000005", host_rvalid, host_gnt, host_rdata[0]); end
        @(negedge clk);
        dev_rvalid = 1'b0;
    endtask

    task automatic test_dev_stall();
        int bad = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            host_req = 2'b10; dev_gnt = 1'b0;
            #1;
            if (dev_req !== 1'b1 || host_gnt !== 2'b00 || dev_addr !== 32'h200) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); end
        @(negedge clk);
        host_req = 2'b11; dev_gnt = 1'b1;
        #1;
        checks++; if (host_gnt !== 2'b01 || dev_addr !== 32'h100) begin errors++; $display("FAIL stall_late_winner got=%b/%h exp=01/00000100", host_gnt, dev_addr); end
        @(negedge clk);
        host_req = 2'b10; dev_rvalid = 1'b1; dev_rdata = 32'h1111_2222;
        #1;
        checks++; if (host_rvalid !== 2'b01 || host_gnt !== 2'b10) begin errors++; $display("FAIL stall_b2b got=%b/%b exp=01/10", host_rvalid, host_gnt); end
        @(negedge clk);
        host_req = 2'b00; dev_gnt = 1'b0; dev_rdata = 32'h3333_4444;
        #1;
        checks++; if (host_rvalid !== 2'b10 || host_rdata[1] !== 32'h3333_4444) begin errors++; $display("FAIL stall_resp1 got=%b/%h exp=10/33334444", host_rvalid, host_rdata[1]); end
        @(negedge clk);
        dev_rvalid = 1'b0;
    endtask

    task automatic test_timeout();
        int bad = 0;
        do_reset();
        @(negedge clk);
        host_req = 2'b01; dev_gnt = 1'b1;
        #1;
        checks++; if (host_gnt !== 2'b01) begin errors++; $display("FAIL to_gnt got=%b exp=01", host_gnt); end
        for (int k = 1; k <= 63; k++) begin
            @(negedge clk);
            host_req = 2'b00; dev_gnt = 1'b0;
            #1;
            if (host_rvalid !== 2'b00 || dev_req !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL to_quiet got=%0d bad cycles exp=0", bad); end
        @(negedge clk);
        host_req = 2'b10; dev_gnt = 1'b1; dev_rdata = 32'h5555_5555;
        #1;
        checks++; if (host_rvalid !== 2'b01 || host_err !== 2'b01) begin errors++; $display("FAIL to_err got=%b/%b exp=01/01", host_rvalid, host_err); end
        checks++; if (host_rdata[0] !== 32'h0) begin errors++; $display("FAIL to_rdata got=%h exp=0", host_rdata[0]); end
        checks++; if (host_gnt !== 2'b00 || dev_req !== 1'b0) begin errors++; $display("FAIL to_no_issue got=%b/%b exp=00/0", host_gnt, dev_req); end
        @(negedge clk);
        host_req = 2'b00; dev_gnt = 1'b0; dev_rvalid = 1'b1; dev_rdata = 32'h7777_7777;
        #1;
        checks++; if (host_rvalid !== 2'b00 || host_rdata[0] !== 32'h0) begin errors++; $display("FAIL to_stray got=%b/%h exp=00/0", host_rvalid, host_rdata[0]); end
        @(negedge clk);
        dev_rvalid = 1'b0; dev_rdata = '0;
    endtask

    task automatic test_write_err();
        do_reset();
        @(negedge clk);
        host_req = 2'b10; host_we = 2'b10; host_be[1] = 4'b0011;
        host_wdata[1] = 32'h1234_5678; host_addr[1] = 32'h0000_2000; dev_gnt = 1'b1;
        #1;
        checks++; if (host_gnt !== 2'b10) begin errors++; $display("FAIL wr_gnt got=%b exp=10", host_gnt); end
        checks++; if (dev_we !== 1'b1 || dev_be !== 4'b0011 || dev_wdata !== 32'h1234_5678 || dev_addr !== 32'h2000) begin errors++; $display("FAIL wr_fields got=%b/%b/%h/%h exp=1/0011/12345678/00002000", dev_we, dev_be, dev_wdata, dev_addr); end
        @(negedge clk);
        host_req = 2'b00; host_we = 2'b00; dev_gnt = 1'b0; dev_rvalid = 1'b1; dev_err = 1'b1;
        #1;
        checks++; if (host_rvalid !== 2'b10 || host_err !== 2'b10) begin errors++; $display("FAIL wr_err got=%b/%b exp=10/10", host_rvalid, host_err); end
        @(negedge clk);
        dev_rvalid = 1'b0; dev_err = 1'b0;
    endtask

    task automatic test_reset_busy();
        do_reset();
        @(negedge clk);
        host_req = 2'b01; dev_gnt = 1'b1;
        #1;
        checks++; if (host_gnt !== 2'b01) begin errors++; $display("FAIL rb_gnt got=%b exp=01", host_gnt); end
        @(negedge clk);
        host_req = 2'b00; dev_gnt = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; dev_rvalid = 1'b1; dev_rdata = 32'h9999_9999;
        #1;
        checks++; if (host_rvalid !== 2'b00 || dev_req !== 1'b0 || host_gnt !== 2'b00) begin errors++; $display("FAIL rb_idle got=%b/%b/%b exp=00/0/00", host_rvalid, dev_req, host_gnt); end
        @(negedge clk);
        dev_rvalid = 1'b0; host_req = 2'b11; dev_gnt = 1'b1;
        #1;
        checks++; if (host_gnt !== 2'b01) begin errors++; $display("FAIL rb_prio got=%b exp=01", host_gnt); end
        @(negedge clk);
        host_req = 2'b00; dev_gnt = 1'b0; dev_rvalid = 1'b1;
        #1;
        checks++; if (host_rvalid !== 2'b01) begin errors++; $display("FAIL rb_resp got=%b exp=01", host_rvalid); end
        @(negedge clk);
        dev_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_alternate();
        test_dev_stall();
        test_timeout();
        test_write_err();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
